// File: rtl/mem_access_unit_pkg.sv
// Shared opcode codes and decode helpers for the Yttrium data-memory access unit.
// Opcode values are the MIPS-style major opcodes of the load/store instructions.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LWL) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWR);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) || (op == OP_SW) ||
           (op == OP_SWR);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Unaligned-word and byte ops are never misaligned.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    return (((op == OP_LW) || (op == OP_SW)) && (lo != 2'b00)) ||
           (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && lo[0]);
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Maps a store opcode, byte offset and rt value to big-endian byte enables and
// lane-shifted write data. Loads get all enables set and zero write data.
module store_lane_gen
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rt_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = '0;
    case (op_i)
      OP_SW: wdata_o = rt_i;
      OP_SH: begin
        be_o    = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o = {2{rt_i[15:0]}};
      end
      OP_SB: begin
        be_o    = 4'b1000 >> addr_lo_i;
        wdata_o = {4{rt_i[7:0]}};
      end
      OP_SWL: begin
        be_o    = 4'b1111 >> addr_lo_i;
        wdata_o = rt_i >> {addr_lo_i, 3'b000};
      end
      // ~addr_lo_i is 3-k for a 2-bit offset.
      OP_SWR: begin
        be_o    = 4'b1111 << (~addr_lo_i);
        wdata_o = rt_i << {~addr_lo_i, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: registers an EXE load/store, runs the bus req/ack
// handshake with a timeout, and reports completion or misalignment/timeout errors.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [5:0]  i_instr_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic [1:0]  o_addr_lo,
  output logic [5:0]  o_load_op,
  output logic        o_addr_err,
  output logic        o_bus_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StErr} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      op_q, op_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     rt_q, rt_d;
  logic [31:0]     load_data_q, load_data_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic [3:0]      lane_be;
  logic [31:0]     lane_wdata;

  assign accept = (state_q == StIdle) && i_req && is_mem_op(i_instr_op);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    rt_d        = rt_q;
    load_data_d = load_data_q;
    misalign_d  = misalign_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d       = i_instr_op;
          addr_d     = i_addr;
          rt_d       = i_store_data;
          cnt_d      = '0;
          misalign_d = is_misaligned(i_instr_op, i_addr[1:0]);
          state_d    = misalign_d ? StErr : StBusy;
        end
      end
      StBusy: begin
        // Ack takes priority over an expiring wait counter.
        if (i_bus_ack) begin
          load_data_d = is_load(op_q) ? i_bus_rdata : '0;
          state_d     = StDone;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      rt_q        <= '0;
      load_data_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rt_q        <= rt_d;
      load_data_q <= load_data_d;
      misalign_q  <= misalign_d;
    end
  end

  store_lane_gen u_store_lane_gen (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .rt_i      (rt_q),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata)
  );

  // Outputs are gated by state so nothing leaks outside the cycles they are valid.
  always_comb begin
    o_busy      = accept || (state_q == StBusy);
    o_done      = (state_q == StDone);
    o_addr_err  = (state_q == StErr) && misalign_q;
    o_bus_err   = (state_q == StErr) && !misalign_q;
    o_bus_req   = (state_q == StBusy);
    o_bus_we    = (state_q == StBusy) && is_store(op_q);
    o_bus_addr  = (state_q == StBusy) ? {addr_q[31:2], 2'b00} : '0;
    o_bus_be    = (state_q == StBusy) ? lane_be : '0;
    o_bus_wdata = (state_q == StBusy) ? lane_wdata : '0;
    o_load_data = (state_q == StDone) ? load_data_q : '0;
    o_addr_lo   = ((state_q == StDone) || (state_q == StErr)) ? addr_q[1:0] : '0;
    o_load_op   = ((state_q == StDone) || (state_q == StErr)) ? op_q : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected bus requests
// and completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [5:0]  i_instr_op;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_load_data;
  logic [1:0]  o_addr_lo;
  logic [5:0]  o_load_op;
  logic        o_addr_err;
  logic        o_bus_err;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (i_req),
    .i_instr_op   (i_instr_op),
    .i_addr       (i_addr),
    .i_store_data (i_store_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_load_data  (o_load_data),
    .o_addr_lo    (o_addr_lo),
    .o_load_op    (o_load_op),
    .o_addr_err   (o_addr_err),
    .o_bus_err    (o_bus_err),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_be     (o_bus_be),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_ack    (i_bus_ack),
    .i_bus_rdata  (i_bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic        chk_wdata;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [1:0]  kind;  // 0 done, 1 addr_err, 2 bus_err
    logic        chk_data;
    logic [31:0] data;
    logic [1:0]  lo;
    logic [5:0]  op;
  } cmp_t;

  bus_t bus_q[$];
  cmp_t cmp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] addr, input logic [3:0] be, input logic we,
                          input logic chk_wdata, input logic [31:0] wdata);
    bus_t b;
    b.addr = addr; b.be = be; b.we = we; b.chk_wdata = chk_wdata; b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  task automatic push_cmp(input logic [1:0] kind, input logic chk_data, input logic [31:0] data,
                          input logic [1:0] lo, input logic [5:0] op);
    cmp_t c;
    c.kind = kind; c.chk_data = chk_data; c.data = data; c.lo = lo; c.op = op;
    cmp_q.push_back(c);
  endtask

  // Monitor: bus request fields on every BUSY cycle, completion pulses as they appear.
  bus_t cur_bus;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    cmp_t e;
    logic [2:0] exp_pulse;
    if (o_bus_req) begin
      if (!req_prev) begin
        if (bus_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bus_req: got req=1 addr=0x%08h, expected no request",
                   o_bus_addr);
        end else begin
          cur_bus = bus_q.pop_front();
        end
      end
      check("bus_addr", o_bus_addr, cur_bus.addr);
      check("bus_be", {28'b0, o_bus_be}, {28'b0, cur_bus.be});
      check("bus_we", {31'b0, o_bus_we}, {31'b0, cur_bus.we});
      if (cur_bus.chk_wdata) check("bus_wdata", o_bus_wdata, cur_bus.wdata);
    end
    req_prev = o_bus_req;

    if (o_done || o_addr_err || o_bus_err) begin
      if (cmp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got done=%0b addr_err=%0b bus_err=%0b, expected none",
                 o_done, o_addr_err, o_bus_err);
      end else begin
        e = cmp_q.pop_front();
        exp_pulse = (e.kind == 2'd0) ? 3'b100 : (e.kind == 2'd1) ? 3'b010 : 3'b001;
        check("pulse_kind", {29'b0, o_done, o_addr_err, o_bus_err}, {29'b0, exp_pulse});
        if (e.kind == 2'd0) begin
          check("done_addr_lo", {30'b0, o_addr_lo}, {30'b0, e.lo});
          check("done_op", {26'b0, o_load_op}, {26'b0, e.op});
          if (e.chk_data) check("done_load_data", o_load_data, e.data);
        end
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic exp_busy);
    i_req        = 1'b1;
    i_instr_op   = op;
    i_addr       = addr;
    i_store_data = rt;
    #1;
    check("busy_accept_cycle", {31'b0, o_busy}, {31'b0, exp_busy});
    @(posedge clk); #1;
    i_req        = 1'b0;
    i_instr_op   = '0;
    i_addr       = '0;
    i_store_data = '0;
  endtask

  task automatic ack_after(input int waits, input logic [31:0] rdata);
    repeat (waits) begin
      check("busy_wait", {31'b0, o_busy}, 32'd1);
      @(posedge clk); #1;
    end
    i_bus_ack   = 1'b1;
    i_bus_rdata = rdata;
    #1;
    check("busy_ack_cycle", {31'b0, o_busy}, 32'd1);
    @(posedge clk); #1;
    i_bus_ack   = 1'b0;
    i_bus_rdata = '0;
    check("done_after_ack", {31'b0, o_done}, 32'd1);
    check("busy_in_done", {31'b0, o_busy}, 32'd0);
    @(posedge clk); #1;
    check("idle_req_low", {31'b0, o_bus_req}, 32'd0);
    check("idle_done_low", {31'b0, o_done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    i_req        = 1'b0;
    i_instr_op   = '0;
    i_addr       = '0;
    i_store_data = '0;
    i_bus_ack    = 1'b0;
    i_bus_rdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_bus_req", {31'b0, o_bus_req}, 32'd0);
    check("rst_bus_addr", o_bus_addr, 32'd0);
    check("rst_load_data", o_load_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW with three wait cycles; ack lands in the last cycle before timeout
    push_bus(32'h0000_0100, 4'b1111, 1'b0, 1'b0, 32'h0);
    push_cmp(2'd0, 1'b1, 32'hDEAD_BEEF, 2'd0, OP_LW);
    issue(OP_LW, 32'h0000_0100, 32'h0, 1'b1);
    ack_after(3, 32'hDEAD_BEEF);

    // SB zero-wait: done two cycles after acceptance
    push_bus(32'h0000_0200, 4'b0001, 1'b1, 1'b1, 32'h7878_7878);
    push_cmp(2'd0, 1'b0, 32'h0, 2'd3, OP_SB);
    issue(OP_SB, 32'h0000_0203, 32'h1234_5678, 1'b1);
    ack_after(0, 32'hFFFF_FFFF);

    push_bus(32'h0000_0300, 4'b0111, 1'b1, 1'b1, 32'h00AA_BBCC);
    push_cmp(2'd0, 1'b0, 32'h0, 2'd1, OP_SWL);
    issue(OP_SWL, 32'h0000_0301, 32'hAABB_CCDD, 1'b1);
    ack_after(1, 32'h0);

    push_bus(32'h0000_0300, 4'b1100, 1'b1, 1'b1, 32'hCCDD_0000);
    push_cmp(2'd0, 1'b0, 32'h0, 2'd1, OP_SWR);
    issue(OP_SWR, 32'h0000_0301, 32'hAABB_CCDD, 1'b1);
    ack_after(0, 32'h0);

    push_bus(32'h0000_0400, 4'b0011, 1'b1, 1'b1, 32'hBEEF_BEEF);
    push_cmp(2'd0, 1'b0, 32'h0, 2'd2, OP_SH);
    issue(OP_SH, 32'h0000_0402, 32'h1234_BEEF, 1'b1);
    ack_after(0, 32'h0);

    push_bus(32'h0000_0500, 4'b1111, 1'b1, 1'b1, 32'hCAFE_F00D);
    push_cmp(2'd0, 1'b0, 32'h0, 2'd0, OP_SW);
    issue(OP_SW, 32'h0000_0500, 32'hCAFE_F00D, 1'b1);
    ack_after(2, 32'h0);

    push_bus(32'h0000_0600, 4'b1111, 1'b0, 1'b0, 32'h0);
    push_cmp(2'd0, 1'b1, 32'h1122_3344, 2'd3, OP_LBU);
    issue(OP_LBU, 32'h0000_0603, 32'h0, 1'b1);
    ack_after(0, 32'h1122_3344);

    // Misaligned LH and SW: one-cycle addr_err, no bus request
    push_cmp(2'd1, 1'b0, 32'h0, 2'd1, OP_LH);
    issue(OP_LH, 32'h0000_0401, 32'h0, 1'b1);
    check("lh_addr_err", {31'b0, o_addr_err}, 32'd1);
    check("lh_no_req", {31'b0, o_bus_req}, 32'd0);
    @(posedge clk); #1;
    check("lh_err_one_cycle", {31'b0, o_addr_err}, 32'd0);

    push_cmp(2'd1, 1'b0, 32'h0, 2'd2, OP_SW);
    issue(OP_SW, 32'h0000_0502, 32'h1, 1'b1);
    check("sw_addr_err", {31'b0, o_addr_err}, 32'd1);
    @(posedge clk); #1;

    // Non-memory opcode is ignored
    issue(6'h0F, 32'h0000_0900, 32'h0, 1'b0);
    check("nonmem_no_req", {31'b0, o_bus_req}, 32'd0);
    check("nonmem_not_busy", {31'b0, o_busy}, 32'd0);

    // Timeout: four BUSY cycles without ack, then bus_err
    push_bus(32'h0000_0700, 4'b1111, 1'b0, 1'b0, 32'h0);
    push_cmp(2'd2, 1'b0, 32'h0, 2'd0, OP_LW);
    issue(OP_LW, 32'h0000_0700, 32'h0, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("timeout_still_req", {31'b0, o_bus_req}, 32'd1);
    end
    @(posedge clk); #1;
    check("timeout_bus_err", {31'b0, o_bus_err}, 32'd1);
    check("timeout_not_busy", {31'b0, o_busy}, 32'd0);
    @(posedge clk); #1;
    check("timeout_back_idle", {31'b0, o_bus_req | o_bus_err}, 32'd0);

    // Reset during BUSY: everything drops, no pulse
    push_bus(32'h0000_0800, 4'b1111, 1'b0, 1'b0, 32'h0);
    issue(OP_LW, 32'h0000_0800, 32'h0, 1'b1);
    check("pre_rst_req", {31'b0, o_bus_req}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_req", {31'b0, o_bus_req}, 32'd0);
    check("rst_mid_busy", {31'b0, o_busy}, 32'd0);
    check("rst_mid_pulses", {29'b0, o_done, o_addr_err, o_bus_err}, 32'd0);
    check("rst_mid_addr", o_bus_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_pulse", {29'b0, o_done, o_addr_err, o_bus_err}, 32'd0);

    push_bus(32'h0000_0804, 4'b1111, 1'b0, 1'b0, 32'h0);
    push_cmp(2'd0, 1'b1, 32'h5A5A_5A5A, 2'd0, OP_LW);
    issue(OP_LW, 32'h0000_0804, 32'h0, 1'b1);
    ack_after(1, 32'h5A5A_5A5A);

    repeat (3) @(posedge clk);
    #1;
    check("bus_queue_drained", bus_q.size(), 32'd0);
    check("cmp_queue_drained", cmp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
